fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 hold  input  1  SHALL be the stall from the hazard unit, also wired to the fetch latch.
REQ-005 redirect  input  1  SHALL indicate a taken branch/jump from execute.
REQ-006 redirect_pc  input  32  SHALL be the new fetch target; bits [1:0] are forced to 0.
REQ-007 imem_req  output  1  SHALL request an instruction memory read.
REQ-008 imem_addr  output  32  SHALL be the word-aligned read address, valid while imem_req=1.
REQ-009 imem_gnt  input  1  SHALL mark acceptance of the request in the same cycle.
REQ-010 imem_rvalid  input  1  SHALL mark imem_rdata valid for one cycle.
REQ-011 imem_rdata  input  32  SHALL be the returned instruction word.
REQ-012 readValid  output  1  SHALL qualify pc_out/instr_out toward the fetch latch.
REQ-013 pc_out  output  32  SHALL be the address of instr_out.
REQ-014 instr_out  output  32  SHALL be the fetched instruction.

Function
REQ-015 States SHALL be REQ, WAIT, VALID, DRAIN; at most one memory request outstanding.
REQ-016 REQ: imem_req=1, imem_addr=pc; on imem_gnt: req_pc<=pc, pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0), go WAIT.
REQ-017 WAIT: on imem_rvalid: pc_out<=req_pc, instr_out<=imem_rdata, readValid<=1 next cycle, go VALID.
REQ-018 VALID: readValid SHALL stay 1 with stable pc_out/instr_out while hold=1; first cycle with hold=0 consumes it, readValid<=0, go REQ.
REQ-019 imem_rvalid in REQ, VALID or after reset with no outstanding request SHALL be ignored.
REQ-020 Redirect priority SHALL exceed hold and all other events.
REQ-021 Redirect in REQ: pc<=redirect_pc, no grant recorded even if imem_gnt=1 that cycle; stay REQ.
REQ-022 Redirect in WAIT without rvalid: pc<=redirect_pc, go DRAIN; the pending response SHALL be discarded.
REQ-023 Redirect in WAIT with rvalid same cycle: response discarded, pc<=redirect_pc, go REQ; readValid stays 0.
REQ-024 Redirect in VALID: readValid<=0 next cycle regardless of hold, pc<=redirect_pc, go REQ.
REQ-025 DRAIN: imem_req=0; on imem_rvalid discard data, go REQ; redirect in DRAIN updates pc, stays DRAIN.
REQ-026 Latency: grant-to-readValid SHALL be (memory latency)+1 cycle; readValid is registered.
REQ-027 imem_req SHALL be 0 in WAIT, VALID, DRAIN and during reset.

Reset
REQ-028 While rst=1: state<=REQ, pc<=RESET_PC, req_pc<=0, readValid<=0, pc_out<=0, instr_out<=0; imem_req=0.
REQ-029 Reset mid-transaction SHALL abandon the outstanding request; its late response is ignored per REQ-019.
REQ-030 First cycle after rst falls SHALL drive imem_req=1, imem_addr=RESET_PC.

Structure
REQ-031 Package fetch_pkg SHALL hold the state encoding, INSTR_BYTES=4 and the default RESET_PC.
REQ-032 Single module; no sub-module; next-state logic combinational, all registers in one clocked process.

Verification
REQ-033 Reset release, gnt same cycle, rvalid 2 cycles later with 32'h0000_0013 -> readValid=1, pc_out=0, instr_out=32'h13; next req addr=4.
REQ-034 hold=1 for 3 cycles while VALID -> readValid, pc_out, instr_out stable 3 cycles; drop one cycle after hold=0.
REQ-035 Redirect to 32'h0000_0103 in WAIT, then rvalid 32'hDEAD_BEEF -> data discarded, readValid never 1, next imem_addr=32'h100.
REQ-036 Redirect and rvalid same cycle in WAIT, redirect_pc=32'h200 -> readValid stays 0, next cycle imem_addr=32'h200.
REQ-037 pc=32'hFFFF_FFFC granted -> pc_out=32'hFFFF_FFFC on delivery, next imem_addr=0.
REQ-038 rst asserted in WAIT, rvalid arrives after release -> ignored; imem_addr=RESET_PC, readValid=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding,
// instruction size and the default reset fetch address.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: one outstanding memory request at a time,
// redirect handling with response draining, and a held output slot.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        readValid,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic [31:0]  req_pc_reg, req_pc_next;
  logic [31:0]  pc_out_reg, pc_out_next;
  logic [31:0]  instr_reg, instr_next;
  logic         valid_reg, valid_next;
  logic [31:0]  target;

  assign target = word_align(redirect_pc);

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    req_pc_next = req_pc_reg;
    pc_out_next = pc_out_reg;
    instr_next  = instr_reg;
    valid_next  = valid_reg;
    case (state_reg)
      ST_REQ: begin
        // A redirect wins over a same-cycle grant; the grant is not recorded.
        if (redirect) begin
          pc_next = target;
        end else if (imem_gnt) begin
          req_pc_next = pc_reg;
          pc_next     = pc_reg + INSTR_BYTES;
          state_next  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          pc_next    = target;
          state_next = imem_rvalid ? ST_REQ : ST_DRAIN;
        end else if (imem_rvalid) begin
          pc_out_next = req_pc_reg;
          instr_next  = imem_rdata;
          valid_next  = 1'b1;
          state_next  = ST_VALID;
        end
      end
      ST_VALID: begin
        if (redirect) begin
          pc_next    = target;
          valid_next = 1'b0;
          state_next = ST_REQ;
        end else if (!hold) begin
          valid_next = 1'b0;
          state_next = ST_REQ;
        end
      end
      ST_DRAIN: begin
        // The stale response still has to arrive before a new request may
        // issue, so a redirect here only retargets the pc.
        if (redirect) begin
          pc_next = target;
        end
        if (imem_rvalid) begin
          state_next = ST_REQ;
        end
      end
      default: state_next = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_REQ;
      pc_reg     <= RESET_PC;
      req_pc_reg <= 32'h0;
      pc_out_reg <= 32'h0;
      instr_reg  <= 32'h0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      req_pc_reg <= req_pc_next;
      pc_out_reg <= pc_out_next;
      instr_reg  <= instr_next;
      valid_reg  <= valid_next;
    end
  end

  assign imem_req  = (state_reg == ST_REQ) && !rst;
  assign imem_addr = pc_reg;
  assign readValid = valid_reg;
  assign pc_out    = pc_out_reg;
  assign instr_out = instr_reg;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, a reset-abandon
// sequence, then random traffic against a queue-based reference model.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, hold, redirect, imem_gnt, imem_rvalid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, readValid;
  logic [31:0] imem_addr, pc_out, instr_out;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .hold        (hold),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .readValid   (readValid),
    .pc_out      (pc_out),
    .instr_out   (instr_out)
  );

  typedef struct {
    logic        rst, hold, redir, gnt, rv;
    logic [31:0] rpc, rdata;
    logic        e_req, e_valid;
    logic [31:0] e_addr, e_pc, e_instr;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %08h want %08h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic h, input logic d,
                              input logic [31:0] rpc, input logic g, input logic rv,
                              input logic [31:0] rd, input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.rst = r; v.hold = h; v.redir = d; v.rpc = rpc; v.gnt = g; v.rv = rv; v.rdata = rd;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_instr = ei;
    return v;
  endfunction

  // Drive one cycle of inputs, then check the outputs visible in that cycle.
  task automatic apply(input vec_t v, input string tag);
    @(posedge clk); #1;
    rst = v.rst; hold = v.hold; redirect = v.redir; redirect_pc = v.rpc;
    imem_gnt = v.gnt; imem_rvalid = v.rv; imem_rdata = v.rdata;
    @(negedge clk);
    cyc++;
    chk({tag, ".req"}, {31'b0, imem_req}, {31'b0, v.e_req});
    if (v.e_req) chk({tag, ".addr"}, imem_addr, v.e_addr);
    chk({tag, ".valid"}, {31'b0, readValid}, {31'b0, v.e_valid});
    chk({tag, ".pc_out"}, pc_out, v.e_pc);
    chk({tag, ".instr"}, instr_out, v.e_instr);
    $display("%s: req=%0b addr=%08h valid=%0b pc_out=%08h instr=%08h",
             tag, imem_req, imem_addr, readValid, pc_out, instr_out);
  endtask

  vec_t tbl[25];

  // Reference model: next fetch address, outstanding request (queue of <=1),
  // a discard mark for it, and the delivered instruction slot.
  logic [31:0] m_pc, m_pc_out, m_instr;
  logic        m_have, m_drop;
  logic [31:0] m_q[$];
  logic [31:0] m_addr;
  logic        exp_req;
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_data;

  initial begin
    rst = 1'b1; hold = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    repeat (3) @(posedge clk);

    //           rst hold rdr rpc            gnt rv  rdata          req addr           vld pc_out         instr
    tbl[0]  = mk(1, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0);
    tbl[1]  = mk(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0,          0, 32'h0,          32'h0);
    tbl[2]  = mk(0, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          32'h0);
    tbl[3]  = mk(0, 0, 0, 32'h0,          0, 1, 32'h0000_0013,  0, 32'h0,          0, 32'h0,          32'h0);
    tbl[4]  = mk(0, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          1, 32'h0,          32'h13);
    tbl[5]  = mk(0, 0, 0, 32'h0,          0, 0, 32'h0,          1, 32'h4,          0, 32'h0,          32'h13);
    tbl[6]  = mk(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h4,          0, 32'h0,          32'h13);
    tbl[7]  = mk(0, 0, 0, 32'h0,          0, 1, 32'h00A0_0093,  0, 32'h0,          0, 32'h0,          32'h13);
    tbl[8]  = mk(0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          1, 32'h4,          32'h00A0_0093);
    tbl[9]  = mk(0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          1, 32'h4,          32'h00A0_0093);
    tbl[10] = mk(0, 1, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          1, 32'h4,          32'h00A0_0093);
    tbl[11] = mk(0, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          1, 32'h4,          32'h00A0_0093);
    tbl[12] = mk(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h8,          0, 32'h4,          32'h00A0_0093);
    tbl[13] = mk(0, 0, 1, 32'h0000_0103,  0, 0, 32'h0,          0, 32'h0,          0, 32'h4,          32'h00A0_0093);
    tbl[14] = mk(0, 0, 0, 32'h0,          0, 1, 32'hDEAD_BEEF,  0, 32'h0,          0, 32'h4,          32'h00A0_0093);
    tbl[15] = mk(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h100,        0, 32'h4,          32'h00A0_0093);
    tbl[16] = mk(0, 0, 1, 32'h0000_0200,  0, 1, 32'h1111_1111,  0, 32'h0,          0, 32'h4,          32'h00A0_0093);
    tbl[17] = mk(0, 0, 1, 32'hFFFF_FFFF,  1, 0, 32'h0,          1, 32'h200,        0, 32'h4,          32'h00A0_0093);
    tbl[18] = mk(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, 32'h4,          32'h00A0_0093);
    tbl[19] = mk(0, 0, 0, 32'h0,          0, 1, 32'h0000_006F,  0, 32'h0,          0, 32'h4,          32'h00A0_0093);
    tbl[20] = mk(0, 0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          1, 32'hFFFF_FFFC,  32'h6F);
    tbl[21] = mk(0, 0, 0, 32'h0,          1, 0, 32'h0,          1, 32'h0,          0, 32'hFFFF_FFFC,  32'h6F);
    tbl[22] = mk(0, 0, 0, 32'h0,          0, 1, 32'h1234_5678,  0, 32'h0,          0, 32'hFFFF_FFFC,  32'h6F);
    tbl[23] = mk(0, 1, 1, 32'h0000_0040,  0, 0, 32'h0,          0, 32'h0,          1, 32'h0,          32'h1234_5678);
    tbl[24] = mk(0, 1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h40,         0, 32'h0,          32'h1234_5678);

    for (int i = 0; i < 25; i++) apply(tbl[i], $sformatf("row%0d", i));

    // Reset while a response is outstanding; the late response must be ignored.
    apply(mk(0, 0, 0, 32'h0, 1, 0, 32'h0,         1, 32'h40,  0, 32'h0, 32'h1234_5678), "rstwait.gnt");
    apply(mk(1, 0, 0, 32'h0, 0, 0, 32'h0,         0, 32'h0,   0, 32'h0, 32'h1234_5678), "rstwait.rst");
    apply(mk(0, 0, 0, 32'h0, 0, 1, 32'hCAFE_F00D, 1, RST_PC,  0, 32'h0, 32'h0),         "rstwait.late");
    apply(mk(0, 0, 0, 32'h0, 0, 0, 32'h0,         1, RST_PC,  0, 32'h0, 32'h0),         "rstwait.after");

    // Random traffic with a variable-latency memory.
    m_pc = RST_PC; m_pc_out = 32'h0; m_instr = 32'h0; m_have = 1'b0; m_drop = 1'b0;
    m_q.delete();
    mem_pend = 1'b0; mem_cnt = 0; mem_data = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst         = (i < 2) || ($urandom_range(0, 199) == 0);
      hold        = ($urandom_range(0, 2) == 0);
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      imem_gnt    = ($urandom_range(0, 1) == 1);
      imem_rvalid = mem_pend && (mem_cnt == 0);
      imem_rdata  = imem_rvalid ? mem_data : $urandom;
      @(negedge clk);
      cyc++;
      exp_req = !rst && (m_q.size() == 0) && !m_have;
      chk("rnd.req", {31'b0, imem_req}, {31'b0, exp_req});
      if (exp_req) chk("rnd.addr", imem_addr, m_pc);
      chk("rnd.valid", {31'b0, readValid}, {31'b0, m_have});
      chk("rnd.pc_out", pc_out, m_pc_out);
      chk("rnd.instr", instr_out, m_instr);

      if (rst) begin
        m_pc = RST_PC; m_q.delete(); m_drop = 1'b0;
        m_have = 1'b0; m_pc_out = 32'h0; m_instr = 32'h0;
      end else if (m_q.size() != 0) begin
        if (redirect) begin
          m_pc   = redirect_pc & 32'hFFFF_FFFC;
          m_drop = 1'b1;
        end
        if (imem_rvalid) begin
          m_addr = m_q.pop_front();
          if (!m_drop) begin
            m_have = 1'b1; m_pc_out = m_addr; m_instr = imem_rdata;
            $display("rnd deliver @%0d: pc=%08h instr=%08h", cyc, m_addr, imem_rdata);
          end
          m_drop = 1'b0;
        end
      end else if (m_have) begin
        if (redirect) begin
          m_pc = redirect_pc & 32'hFFFF_FFFC; m_have = 1'b0;
        end else if (!hold) begin
          m_have = 1'b0;
        end
      end else begin
        if (redirect) begin
          m_pc = redirect_pc & 32'hFFFF_FFFC;
        end else if (imem_gnt) begin
          m_q.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end

      if (rst) begin
        mem_pend = 1'b0;
      end else begin
        if (imem_rvalid) mem_pend = 1'b0;
        else if (mem_pend) mem_cnt--;
        if (imem_req && imem_gnt && !redirect) begin
          mem_pend = 1'b1;
          mem_cnt  = $urandom_range(0, 2);
          mem_data = $urandom;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
